// File: rtl/alu_input_sequencer.sv
// Operator front end for an ALU: debounced-by-synchronizer enter/undo buttons
// step through operand A, operand B and opcode entry, then capture the result.
module alu_input_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         enter,
    input  logic         undo,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_status,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [1:0]   opcode,
    output logic [N-1:0] result_q,
    output logic [3:0]   status_q,
    output logic         valid,
    output logic [2:0]   state_id,
    output logic [N-1:0] display
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CAPTURE = 3'd3,
        SHOW    = 3'd4
    } state_t;

    logic [1:0] btn;
    logic [1:0] pulse;
    logic       enter_p;
    logic       undo_p;

    assign btn     = {undo, enter};
    assign enter_p = pulse[0];
    assign undo_p  = pulse[1];

    // Two synchronizer stages plus an edge-detect stage per button.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sync_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q <= 3'b000;
                end else begin
                    sync_q <= {sync_q[1:0], btn[gi]};
                end
            end
            assign pulse[gi] = sync_q[1] & ~sync_q[2];
        end
    endgenerate

    state_t       state_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [1:0]   op_q;
    logic [N-1:0] res_q;
    logic [3:0]   stat_q;
    logic         valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            stat_q  <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            // Undo always wins over a coincident enter.
            case (state_q)
                WAIT_A: begin
                    if (!undo_p && enter_p) begin
                        a_q     <= data_in;
                        valid_q <= 1'b0;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (undo_p) begin
                        state_q <= WAIT_A;
                    end else if (enter_p) begin
                        b_q     <= data_in;
                        valid_q <= 1'b0;
                        state_q <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (undo_p) begin
                        state_q <= WAIT_B;
                    end else if (enter_p) begin
                        op_q    <= data_in[1:0];
                        valid_q <= 1'b0;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Button pulses seen here are dropped on purpose.
                    res_q   <= alu_result;
                    stat_q  <= alu_status;
                    valid_q <= 1'b1;
                    state_q <= SHOW;
                end
                SHOW: begin
                    if (undo_p) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_OP;
                    end else if (enter_p) begin
                        valid_q <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    always_comb begin
        display = res_q;
        case (state_q)
            WAIT_A, WAIT_B: display = data_in;
            WAIT_OP:        display = {{(N-2){1'b0}}, data_in[1:0]};
            default:        display = res_q;
        endcase
    end

    assign A        = a_q;
    assign B        = b_q;
    assign opcode   = op_q;
    assign result_q = res_q;
    assign status_q = stat_q;
    assign valid    = valid_q;
    assign state_id = state_q;

endmodule

// File: doc/alu_input_sequencer.md
ALU_INPUT_SEQUENCER -- requirements
Module: alu_input_sequencer

Interface
REQ-001 SHALL have parameter: N, 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: data_in  input  N  operand/opcode value from switches; opcode taken from data_in[1:0].
REQ-005 SHALL have port: enter  input  1  asynchronous pushbutton, advance sequence.
REQ-006 SHALL have port: undo  input  1  asynchronous pushbutton, step back one state.
REQ-007 SHALL have port: alu_result  input  N  combinational result returned by downstream ALU.
REQ-008 SHALL have port: alu_status  input  4  ALU flags {N,Z,C,V}, N in bit 3.
REQ-009 SHALL have port: A  output  N  registered operand A to ALU.
REQ-010 SHALL have port: B  output  N  registered operand B to ALU.
REQ-011 SHALL have port: opcode  output  2  registered opcode to ALU (00 ADD, 01 SUB, 10 OR, 11 AND).
REQ-012 SHALL have port: result_q  output  N  captured ALU result.
REQ-013 SHALL have port: status_q  output  4  captured ALU flags.
REQ-014 SHALL have port: valid  output  1  high while result_q/status_q belong to current A/B/opcode.
REQ-015 SHALL have port: state_id  output  3  current state encoding (see REQ-019).
REQ-016 SHALL have port: display  output  N  value for display driver.

Function
REQ-017 SHALL pass enter and undo each through a 2-flop synchronizer plus a third flop; pulse = stage2 & ~stage3.
REQ-018 SHALL act on a pulse at the rising edge where the pulse is high: 3rd rising edge after the input is first sampled high; one action per low-to-high transition regardless of hold time.
REQ-019 SHALL implement states WAIT_A=0, WAIT_B=1, WAIT_OP=2, CAPTURE=3, SHOW=4; state_id = encoding.
REQ-020 enter pulse: WAIT_A -> load A=data_in, go WAIT_B; WAIT_B -> load B=data_in, go WAIT_OP; WAIT_OP -> load opcode=data_in[1:0], go CAPTURE; SHOW -> clear valid, go WAIT_A.
REQ-021 CAPTURE SHALL last exactly one cycle: load result_q=alu_result, status_q=alu_status, set valid=1, go SHOW unconditionally.
REQ-022 Pulses arriving while in CAPTURE SHALL be discarded, not queued.
REQ-023 undo pulse: WAIT_B -> WAIT_A; WAIT_OP -> WAIT_B; SHOW -> WAIT_OP with valid cleared; no effect in WAIT_A; registers A/B/opcode unchanged by undo.
REQ-024 Simultaneous enter and undo pulses: undo SHALL take priority, enter discarded.
REQ-025 A, B, opcode SHALL hold value until overwritten by REQ-020; no register changes except as listed.
REQ-026 valid SHALL be 1 only in SHOW; any load of A, B or opcode SHALL leave valid=0.
REQ-027 display: WAIT_A/WAIT_B -> data_in (live); WAIT_OP -> {N-2 zeros, data_in[1:0]}; CAPTURE/SHOW -> result_q.
REQ-028 No arithmetic performed internally; widths pass through unmodified.

Reset
REQ-029 reset high SHALL immediately (no clock) force state=WAIT_A, A=B=0, opcode=00, result_q=0, status_q=0, valid=0, all synchronizer flops=0.
REQ-030 Reset asserted mid-sequence (any state, including CAPTURE) SHALL abandon the sequence; post-release behaviour identical to power-up.
REQ-031 A button held high across reset release SHALL generate one pulse after release (synchronizer starts at 0).

Verification
REQ-032 ADD: enter with data_in=8'h3C, 8'h05, 8'h00, ALU model attached -> A=3C, B=05, opcode=00, one CAPTURE cycle, then SHOW, result_q=8'h41, status_q=4'b0000, valid=1, display=8'h41.
REQ-033 SUB zero: A=8'h05, B=8'h05, opcode=01 -> result_q=8'h00, status_q Z=1, C per ALU model; then enter -> WAIT_A, valid=0, A still 05.
REQ-034 Held/undo: enter held 50 cycles in WAIT_A -> exactly one advance to WAIT_B; undo in WAIT_OP -> WAIT_B, B unchanged; undo in WAIT_A -> no change.
REQ-035 Simultaneous: enter and undo rise same cycle in WAIT_B -> state WAIT_A, B not loaded.
REQ-036 Reset mid-op: assert reset asynchronously in CAPTURE (between edges) -> all outputs zero before next edge, state_id=0, valid=0.
REQ-037 Discard: enter pulse coinciding with CAPTURE -> state SHOW, not WAIT_A.
